text_reader: RTL and testbench
==============================

Name: text_reader

Overview:
- Sequential read-out engine for the 15x20 character text RAM that the editor side fills.
- On a start pulse it scans the RAM row by row, column by column, and streams the stored characters as bytes over a valid/ready interface. A newline is inserted at the end of each row.
- Intended consumers are a UART transmitter or an interpreter front-end.
- It drives read_enable high for the whole scan, so the editor suppresses writes and the RAM address mux selects read_addr.

Parameters:
- ROWS, 15, number of text rows scanned (row index occupies address bits [8:5]).
- COLS, 20, number of columns per row (column index occupies address bits [4:0]).
- NEWLINE, 8'h0A, byte emitted after each row.
- SKIP_NULL, 1, when 1 null cells (8'h00) are dropped; when 0 they are emitted as 8'h20.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a scan; ignored while busy.
- abort  input  1  cancel the scan in progress.
- ram_rdata  input  8  text RAM read data; registered RAM, valid one cycle after read_addr is presented.
- read_enable  output  1  high while scanning; blocks editor writes.
- read_addr  output  9  {row[3:0], col[4:0]}.
- out_data  output  8  streamed byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts the byte.
- out_last  output  1  qualifies the final NEWLINE of the scan.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a scan completes normally.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State becomes IDLE; row=0, col=0, data_reg=0.
  - All outputs are 0: read_enable, read_addr, out_data, out_valid, out_last, busy, done.
  - rst overrides abort, start and any handshake.
- States: IDLE, ADDR, FETCH, EMIT, EOL, DONE.
- IDLE:
  - read_enable=0, read_addr=0.
  - start=1 -> row=0, col=0, go to ADDR.
- ADDR:
  - read_enable=1, read_addr={row,col}.
  - Next state is FETCH.
- FETCH:
  - read_addr is held; ram_rdata is captured into data_reg.
  - If ram_rdata==0 and SKIP_NULL=1, the cell is skipped: advance the column (see below) without entering EMIT.
  - Otherwise go to EMIT; a null cell is stored as 8'h20 when SKIP_NULL=0.
- EMIT:
  - out_valid=1, out_data=data_reg.
  - On out_valid & out_ready, advance the column.
- Column advance:
  - If col==COLS-1, go to EOL.
  - Otherwise col=col+1 and go to ADDR.
- EOL:
  - out_valid=1, out_data=NEWLINE, out_last=(row==ROWS-1).
  - On handshake at the last row, go to DONE.
  - On handshake at any other row, row=row+1, col=0, go to ADDR.
- DONE:
  - done=1 for exactly one cycle; read_enable=0.
  - Next state is IDLE.
- Handshake rules:
  - A byte transfers on a cycle where out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0: out_data, out_last and read_addr are held, and row/col do not change.
  - out_valid never deasserts without a transfer, except on abort or rst.
- Throughput:
  - Emitted cell: 3 cycles minimum.
  - Skipped cell: 2 cycles.
  - EOL: 1 cycle minimum.
- abort (any non-IDLE state):
  - Next state is IDLE; out_valid, read_enable and busy are 0 the next cycle.
  - done is not pulsed.
  - abort beats a simultaneous handshake; that byte is considered not transferred.
- start:
  - start together with abort in IDLE: start wins.
  - start in any non-IDLE state has no effect.
- Width rules:
  - row is 4 bits and col is 5 bits; neither may wrap past ROWS-1 or COLS-1.
  - Addresses 20..31 within a row are never issued.
- Stream length:
  - Always exactly ROWS newlines per scan.
  - Total bytes = ROWS + (non-null cells) when SKIP_NULL=1, or ROWS*(COLS+1) when SKIP_NULL=0.

Test Plan:
- Reset: assert rst mid-EMIT with out_valid=1 -> next cycle out_valid=0, read_enable=0, busy=0, read_addr=0; a later start begins again at addr 0.
- Empty RAM, SKIP_NULL=1, out_ready=1, start pulse:
  - Stream is exactly 15 bytes of 8'h0A, with out_last=1 only on the 15th.
  - done pulses once, on the cycle after the 15th transfer.
  - read_enable is high from the cycle after start until DONE.
- RAM[9'h000]=8'h41 and RAM[{4'd1,5'd5}]=8'h42:
  - Stream is 8'h41, 8'h0A, 8'h42, 8'h0A, then 13 x 8'h0A.
  - read_addr visits 9'h025 and never visits 9'h014..9'h01F.
- Backpressure: hold out_ready=0 for 5 cycles while out_data=8'h41 -> out_valid, out_data and read_addr stay constant for those 5 cycles; the transfer completes on the first ready cycle and the scan resumes at col 1.
- Abort during row 3 EMIT, together with out_ready=1 -> next cycle IDLE with all outputs 0; no done pulse; that byte is not counted as transferred.
- Parameter and busy checks:
  - SKIP_NULL=0 with an empty RAM -> 315 bytes, each row being 20 x 8'h20 followed by 8'h0A.
  - A start pulse issued mid-scan leaves the byte count and sequence unchanged.

Source files
------------

// File: rtl/text_reader.sv
// Scans the character text RAM row by row and streams its contents as bytes
// over a valid/ready interface, appending NEWLINE after every row.
module text_reader #(
  parameter int unsigned ROWS      = 15,
  parameter int unsigned COLS      = 20,
  parameter logic [7:0]  NEWLINE   = 8'h0A,
  parameter bit          SKIP_NULL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] ram_rdata,
  output logic       read_enable,
  output logic [8:0] read_addr,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, ADDR, FETCH, EMIT, EOL, DONE} state_t;

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);

  state_t     state;
  logic [3:0] row;
  logic [4:0] col;
  logic [7:0] data_reg;

  // data_reg doubles as the output byte register (cell data or NEWLINE)
  assign out_data = data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      data_reg    <= '0;
      read_enable <= 1'b0;
      read_addr   <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state       <= IDLE;
        data_reg    <= '0;
        read_enable <= 1'b0;
        read_addr   <= '0;
        out_valid   <= 1'b0;
        out_last    <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              row         <= '0;
              col         <= '0;
              read_enable <= 1'b1;
              read_addr   <= '0;
              busy        <= 1'b1;
              state       <= ADDR;
            end
          end
          ADDR: state <= FETCH;
          FETCH: begin
            if (SKIP_NULL && ram_rdata == 8'h00) begin
              data_reg <= '0;
              if (col == LAST_COL) begin
                data_reg  <= NEWLINE;
                out_valid <= 1'b1;
                out_last  <= (row == LAST_ROW);
                state     <= EOL;
              end else begin
                col       <= col + 5'd1;
                read_addr <= {row, col + 5'd1};
                state     <= ADDR;
              end
            end else begin
              data_reg  <= (ram_rdata == 8'h00) ? 8'h20 : ram_rdata;
              out_valid <= 1'b1;
              state     <= EMIT;
            end
          end
          EMIT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (col == LAST_COL) begin
                data_reg  <= NEWLINE;
                out_valid <= 1'b1;
                out_last  <= (row == LAST_ROW);
                state     <= EOL;
              end else begin
                col       <= col + 5'd1;
                read_addr <= {row, col + 5'd1};
                state     <= ADDR;
              end
            end
          end
          EOL: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (row == LAST_ROW) begin
                data_reg    <= '0;
                read_enable <= 1'b0;
                read_addr   <= '0;
                done        <= 1'b1;
                state       <= DONE;
              end else begin
                row       <= row + 4'd1;
                col       <= '0;
                read_addr <= {row + 4'd1, 5'd0};
                state     <= ADDR;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_reader.sv
// Directed bench for text_reader: expected bytes are queued as each scan is
// set up and compared against every handshake the DUT performs.
module tb_text_reader;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, out_ready;
  logic [7:0] ram_rdata;
  logic       read_enable, out_valid, out_last, busy, done;
  logic [8:0] read_addr;
  logic [7:0] out_data;

  logic       start0, out_ready0;
  logic [7:0] ram_rdata0;
  logic       read_enable0, out_valid0, out_last0, busy0, done0;
  logic [8:0] read_addr0;
  logic [7:0] out_data0;

  logic [7:0] mem [0:511];

  text_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ram_rdata(ram_rdata),
    .read_enable(read_enable), .read_addr(read_addr), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  text_reader #(.SKIP_NULL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(1'b0), .ram_rdata(ram_rdata0),
    .read_enable(read_enable0), .read_addr(read_addr0), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_last(out_last0),
    .busy(busy0), .done(done0)
  );

  always @(posedge clk) ram_rdata <= mem[read_addr];

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];
  exp_t e, e0;
  int   total = 0;
  int   bad = 0;
  int   xfers = 0;
  int   xfers0 = 0;
  int   bad_addr = 0;
  bit   saw_25 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    exp_t x;
    x.d = d;
    x.l = l;
    q.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted byte is matched against the expected queue.
  always @(negedge clk) begin
    if (!rst && !abort && out_valid && out_ready) begin
      xfers++;
      if (q.size() == 0) check("sb_underflow", q.size(), 1);
      else begin
        e = q.pop_front();
        check("sb_data", out_data, e.d);
        check("sb_last", out_last, e.l);
      end
    end
    if (read_enable) begin
      if (read_addr[4:0] > 5'd19) bad_addr++;
      if (read_addr == 9'h025) saw_25 = 1'b1;
    end
    if (!rst && out_valid0 && out_ready0) begin
      xfers0++;
      if (q0.size() == 0) check("sb0_underflow", q0.size(), 1);
      else begin
        e0 = q0.pop_front();
        check("sb0_data", out_data0, e0.d);
        check("sb0_last", out_last0, e0.l);
      end
    end
  end

  task automatic run_to_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick;
      n++;
    end
    check(tag, done, 1);
    tick;
  endtask

  task automatic push_b_stream;
    push(8'h41, 1'b0);
    push(8'h0A, 1'b0);
    push(8'h42, 1'b0);
    push(8'h0A, 1'b0);
    for (int r = 2; r < 15; r++) push(8'h0A, r == 14);
  endtask

  initial begin
    int  re_gap, n, done_cnt;
    bit  got, hs_prev;
    exp_t x;

    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start0 = 1'b0; out_ready0 = 1'b0; ram_rdata0 = 8'h00;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    tick; tick; tick;

    check("rst_read_enable", read_enable, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick;

    // Empty RAM: fifteen newlines, done right after the last one.
    xfers = 0;
    for (int r = 0; r < 15; r++) push(8'h0A, r == 14);
    out_ready = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    check("empty_re_after_start", read_enable, 1);
    re_gap = 0; got = 1'b0; hs_prev = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      hs_prev = out_valid && out_ready && out_last;
      tick;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!read_enable) re_gap++;
    end
    check("empty_done_seen", got, 1);
    check("empty_done_timing", hs_prev, 1);
    check("empty_re_gap", re_gap, 0);
    check("empty_re_in_done", read_enable, 0);
    check("empty_xfers", xfers, 15);
    tick;
    check("empty_done_single", done, 0);
    check("empty_busy_idle", busy, 0);
    check("empty_q_left", q.size(), 0);

    // Two characters, plus a stray start pulse mid-scan.
    mem[9'h000] = 8'h41;
    mem[{4'd1, 5'd5}] = 8'h42;
    xfers = 0; bad_addr = 0; saw_25 = 1'b0;
    push_b_stream;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 50; i++) tick;
    start = 1'b1; tick; start = 1'b0;
    run_to_done("chars_done", 2000);
    check("chars_xfers", xfers, 17);
    check("chars_saw_025", saw_25, 1);
    check("chars_bad_addr", bad_addr, 0);
    check("chars_q_left", q.size(), 0);

    // Backpressure on the first byte.
    xfers = 0;
    push_b_stream;
    out_ready = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick; n++; end
    check("bp_valid", out_valid, 1);
    check("bp_data", out_data, 8'h41);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 8'h41);
      check("bp_hold_addr", read_addr, 9'h000);
    end
    out_ready = 1'b1;
    tick;
    check("bp_resume_addr", read_addr, 9'h001);
    check("bp_resume_valid", out_valid, 0);
    check("bp_xfers_one", xfers, 1);
    run_to_done("bp_done", 2000);
    check("bp_xfers", xfers, 17);
    check("bp_q_left", q.size(), 0);

    // Abort during a row-3 emit with ready high: that byte is dropped.
    mem[{4'd3, 5'd2}] = 8'h43;
    xfers = 0;
    push(8'h41, 1'b0); push(8'h0A, 1'b0);
    push(8'h42, 1'b0); push(8'h0A, 1'b0);
    push(8'h0A, 1'b0);
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!(out_valid && out_data == 8'h43) && n < 1000) begin tick; n++; end
    check("abort_found_c", out_data, 8'h43);
    check("abort_addr", read_addr, 9'h062);
    abort = 1'b1; tick; abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_re", read_enable, 0);
    check("abort_busy", busy, 0);
    check("abort_addr0", read_addr, 0);
    check("abort_data0", out_data, 0);
    check("abort_last", out_last, 0);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) done_cnt++;
      tick;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_xfers", xfers, 5);
    check("abort_q_left", q.size(), 0);

    // Reset in the middle of an emit, then a fresh start.
    out_ready = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick; n++; end
    check("rst_mid_pre_valid", out_valid, 1);
    rst = 1'b1; tick; rst = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_re", read_enable, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", read_addr, 0);
    start = 1'b1; tick; start = 1'b0;
    check("restart_re", read_enable, 1);
    check("restart_addr", read_addr, 0);
    check("restart_busy", busy, 1);
    abort = 1'b1; tick; abort = 1'b0;
    check("restart_abort_busy", busy, 0);

    // SKIP_NULL=0 instance: every cell becomes a space.
    xfers0 = 0;
    for (int k = 0; k < 315; k++) begin
      x.d = (k % 21 == 20) ? 8'h0A : 8'h20;
      x.l = (k == 314);
      q0.push_back(x);
    end
    out_ready0 = 1'b1;
    start0 = 1'b1; tick; start0 = 1'b0;
    n = 0;
    while (!done0 && n < 3000) begin tick; n++; end
    check("sp_done", done0, 1);
    tick;
    check("sp_xfers", xfers0, 315);
    check("sp_q_left", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
